// File: rtl/boot_mem_ctrl_pkg.sv
// Shared definitions for the boot memory controller.
// Holds the host command encodings, the controller state and region
// encodings, default memory-map constants and the window-hit helper used by
// the address decoder.
package boot_mem_ctrl_pkg;

    localparam logic [31:0] IMEM_BASE_DEF   = 32'h0000_0000;
    localparam logic [31:0] DMEM_BASE_DEF   = 32'h0001_0000;
    localparam int          AW_DEF          = 12;
    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0002_0000;
    localparam logic [31:0] BAD_DATA_DEF    = 32'hDEAD_BEEF;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_HALT  = 2'd3;

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RSP     = 2'd2,
        ST_RUNNING = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_IMEM = 2'd1,
        REG_DMEM = 2'd2
    } region_t;

    // Unsigned offset compare: addresses below base wrap to huge offsets and
    // therefore miss, so a single compare covers both window edges.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned aw);
        logic [31:0] offset;
        offset = addr - base;
        return offset < (32'd4 << aw);
    endfunction

endpackage

// File: rtl/boot_addr_decode.sv
// Byte address -> RAM region and word index.
// Ports:
//   addr     in   32  byte address (bits [1:0] ignored)
//   region   out      REG_IMEM / REG_DMEM / REG_NONE
//   word_idx out  AW  word index addr[AW+1:2]
// The instruction window is tested first should the two windows ever overlap.
module boot_addr_decode
    import boot_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
    parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
    parameter int          AW        = AW_DEF
) (
    input  logic [31:0]   addr,
    output region_t       region,
    output logic [AW-1:0] word_idx
);

    always_comb begin
        region = REG_NONE;
        if (in_window(addr, IMEM_BASE, AW)) begin
            region = REG_IMEM;
        end else if (in_window(addr, DMEM_BASE, AW)) begin
            region = REG_DMEM;
        end
    end

    assign word_idx = addr[AW+1:2];

endmodule

// File: rtl/boot_mem_ctrl.sv
// Boot memory controller: owns the instruction and data RAM ports and
// sequences between a halted core (host loads/inspects memory over a
// valid/ready command stream) and a running core (combinational passthrough).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_*                       host command stream (WRITE/READ/RUN/HALT)
//   rsp_*                       host read response stream
//   cpu_reset                   holds the core in reset whenever not RUNNING
//   cpu_pc, cpu_instr           core fetch port
//   cpu_mem_*                   core data port
//   imem_*, dmem_*              single-port synchronous RAMs, 1-cycle read
//   running, done, exit_code    status; done/exit_code set by a tohost store
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HALTED  | core in reset, host owns both RAMs, any command accepted
// ST_RD_WAIT | host read issued, RAM data arrives this cycle
// ST_RSP     | read data presented, waiting for rsp_ready
// ST_RUNNING | core owns the RAMs, only HALT accepted from the host
module boot_mem_ctrl
    import boot_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE   = IMEM_BASE_DEF,
    parameter logic [31:0] DMEM_BASE   = DMEM_BASE_DEF,
    parameter int          AW          = AW_DEF,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
    parameter logic [31:0] BAD_DATA    = BAD_DATA_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [31:0]   cmd_addr,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          cpu_reset,
    input  logic [31:0]   cpu_pc,
    output logic [31:0]   cpu_instr,
    input  logic [31:0]   cpu_mem_addr,
    input  logic [31:0]   cpu_mem_wdata,
    input  logic [3:0]    cpu_mem_write,
    output logic [31:0]   cpu_mem_rdata,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          imem_we,
    input  logic [31:0]   imem_rdata,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_wstrb,
    input  logic [31:0]   dmem_rdata,
    output logic          running,
    output logic          done,
    output logic [31:0]   exit_code
);

    state_t        state;
    state_t        state_nxt;
    region_t       host_region;
    region_t       core_region;
    region_t       rd_region;
    logic [AW-1:0] host_idx;
    logic [AW-1:0] core_idx;
    logic          cmd_fire;
    logic          tohost_store;
    logic          pc_unused;

    // The fetch path needs only the word index; the rest of the PC is ignored.
    assign pc_unused = ^{cpu_pc[31:AW+2], cpu_pc[1:0]};

    boot_addr_decode #(
        .IMEM_BASE (IMEM_BASE),
        .DMEM_BASE (DMEM_BASE),
        .AW        (AW)
    ) u_host_dec (
        .addr     (cmd_addr),
        .region   (host_region),
        .word_idx (host_idx)
    );

    boot_addr_decode #(
        .IMEM_BASE (IMEM_BASE),
        .DMEM_BASE (DMEM_BASE),
        .AW        (AW)
    ) u_core_dec (
        .addr     (cpu_mem_addr),
        .region   (core_region),
        .word_idx (core_idx)
    );

    assign cmd_fire     = cmd_valid & cmd_ready;
    assign tohost_store = (state == ST_RUNNING) && (cpu_mem_write != 4'h0) &&
                          (cpu_mem_addr == TOHOST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HALTED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALTED: begin
                if (cmd_fire && cmd_op == OP_READ) begin
                    state_nxt = ST_RD_WAIT;
                end else if (cmd_fire && cmd_op == OP_RUN) begin
                    state_nxt = ST_RUNNING;
                end
            end
            ST_RD_WAIT: state_nxt = ST_RSP;
            ST_RSP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_RUNNING: begin
                // In RUNNING only HALT can fire.
                if (tohost_store || cmd_fire) begin
                    state_nxt = ST_HALTED;
                end
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        cpu_reset  = (state != ST_RUNNING);
        running    = (state == ST_RUNNING);
        imem_addr  = host_idx;
        imem_wdata = cmd_wdata;
        imem_we    = 1'b0;
        dmem_addr  = host_idx;
        dmem_wdata = cmd_wdata;
        dmem_wstrb = 4'h0;
        case (state)
            ST_HALTED: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_op == OP_WRITE) begin
                    imem_we    = (host_region == REG_IMEM);
                    dmem_wstrb = (host_region == REG_DMEM) ? 4'hF : 4'h0;
                end
            end
            ST_RUNNING: begin
                cmd_ready  = cmd_valid && (cmd_op == OP_HALT);
                imem_addr  = cpu_pc[AW+1:2];
                dmem_addr  = core_idx;
                dmem_wdata = cpu_mem_wdata;
                // TOHOST lies outside the data window, so it is never forwarded.
                dmem_wstrb = (core_region == REG_DMEM) ? cpu_mem_write : 4'h0;
            end
            default: ;
        endcase
    end

    assign cpu_instr     = imem_rdata;
    assign cpu_mem_rdata = dmem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_region <= REG_NONE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            done      <= 1'b0;
            exit_code <= 32'h0;
        end else begin
            if (state == ST_HALTED && cmd_fire && cmd_op == OP_READ) begin
                rd_region <= host_region;
            end
            if (state == ST_RD_WAIT) begin
                rsp_valid <= 1'b1;
                case (rd_region)
                    REG_IMEM: rsp_rdata <= imem_rdata;
                    REG_DMEM: rsp_rdata <= dmem_rdata;
                    default:  rsp_rdata <= BAD_DATA;
                endcase
            end else if (state == ST_RSP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (state == ST_HALTED && cmd_fire && cmd_op == OP_RUN) begin
                done <= 1'b0;
            end
            if (tohost_store) begin
                done      <= 1'b1;
                exit_code <= cpu_mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Scoreboarded bench for boot_mem_ctrl with behavioural RAMs and a word-level
// memory-map reference model.
module tb_boot_mem_ctrl;

    localparam int          DEPTH     = 4096;
    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_BASE = 32'h0001_0000;
    localparam logic [31:0] WIN_BYTES = 32'h0000_4000;
    localparam logic [31:0] TOHOST    = 32'h0002_0000;
    localparam logic [31:0] BAD       = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        cpu_reset;
    logic [31:0] cpu_pc, cpu_instr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_write;
    logic [11:0] imem_addr, dmem_addr;
    logic [31:0] imem_wdata, imem_rdata, dmem_wdata, dmem_rdata;
    logic        imem_we;
    logic [3:0]  dmem_wstrb;
    logic        running, done;
    logic [31:0] exit_code;

    always #5 clk = ~clk;

    boot_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_write(cpu_mem_write), .cpu_mem_rdata(cpu_mem_rdata),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
        .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata),
        .running(running), .done(done), .exit_code(exit_code)
    );

    // Behavioural single-port RAMs with registered read.
    logic [31:0] imem_ram [DEPTH];
    logic [31:0] dmem_ram [DEPTH];

    always @(posedge clk) begin
        if (imem_we) imem_ram[imem_addr] <= imem_wdata;
        imem_rdata <= imem_ram[imem_addr];
        for (int b = 0; b < 4; b++) begin
            if (dmem_wstrb[b]) dmem_ram[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
        dmem_rdata <= dmem_ram[dmem_addr];
    end

    // Reference model: memory map as plain word arrays.
    logic [31:0] ref_imem [DEPTH];
    logic [31:0] ref_dmem [DEPTH];
    logic [31:0] written [$];
    logic [31:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    function automatic int region_of(input logic [31:0] a);
        if ((a - IMEM_BASE) < WIN_BYTES) return 1;
        if ((a - DMEM_BASE) < WIN_BYTES) return 2;
        return 0;
    endfunction

    function automatic int widx(input logic [31:0] a, input logic [31:0] base);
        return int'((a - base) >> 2);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (region_of(a) == 1) ref_imem[widx(a, IMEM_BASE)] = d;
        else if (region_of(a) == 2) ref_dmem[widx(a, DMEM_BASE)] = d;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (region_of(a) == 1) return ref_imem[widx(a, IMEM_BASE)];
        if (region_of(a) == 2) return ref_dmem[widx(a, DMEM_BASE)];
        return BAD;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: pops an expected value on every response handshake and checks
    // that a pending response stays stable until it is taken.
    logic        hold_pend;
    logic [31:0] hold_data;
    initial begin
        hold_pend = 1'b0;
        hold_data = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) check("rsp_held_valid", {31'h0, rsp_valid}, 32'h1);
                if (hold_pend && rsp_valid) check("rsp_stable", rsp_rdata, hold_data);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata);
                    end else begin
                        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
                    end
                    hold_pend = 1'b0;
                end else if (rsp_valid) begin
                    hold_pend = 1'b1;
                    hold_data = rsp_rdata;
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    logic hold_rsp;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        acc_imem_we, acc_cpu_reset;
    logic [11:0] acc_imem_addr, acc_dmem_addr;
    logic [3:0]  acc_dmem_wstrb;

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL cmd_accept: got no ready expected accept op %0d", op);
                break;
            end
        end
        acc_imem_we    = imem_we;
        acc_imem_addr  = imem_addr;
        acc_dmem_wstrb = dmem_wstrb;
        acc_dmem_addr  = dmem_addr;
        acc_cpu_reset  = cpu_reset;
        if (cmd_ready && op == 2'd1) exp_q.push_back(model_read(addr));
        if (cmd_ready && op == 2'd0) model_write(addr, wdata);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL rsp_drain: got %0d pending expected 0", exp_q.size());
        end
        tick();
    endtask

    function automatic logic [31:0] rand_addr(input int r);
        logic [31:0] unm [6];
        int idx;
        unm[0] = 32'h0000_4000; unm[1] = 32'h0001_4000; unm[2] = 32'h0003_0000;
        unm[3] = 32'hFFFF_FFFC; unm[4] = 32'h0000_FFFC; unm[5] = TOHOST;
        idx = ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 15);
        if (r == 1) return IMEM_BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
        if (r == 2) return DMEM_BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
        return unm[$urandom_range(0, 5)];
    endfunction

    logic [31:0] prog [3];
    logic [31:0] a, d, e;

    initial begin
        reset = 1'b1; hold_rsp = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        cpu_pc = 32'h0; cpu_mem_addr = 32'h0; cpu_mem_wdata = 32'h0; cpu_mem_write = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_exit_code", exit_code, 32'h0);
        check("rst_running", {31'h0, running}, 32'h0);
        tick();

        // Directed write/read of imem word 1 with response held off.
        send_cmd(2'd0, 32'h0000_0004, 32'h0050_0093);
        check("wr_imem_we", {31'h0, acc_imem_we}, 32'h1);
        check("wr_imem_addr", {20'h0, acc_imem_addr}, 32'h1);
        check("wr_imem_no_dmem", {28'h0, acc_dmem_wstrb}, 32'h0);
        hold_rsp = 1'b1;
        send_cmd(2'd1, 32'h0000_0004, 32'h0);
        @(negedge clk);
        check("rd_wait_no_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        check("rsp_latency", {31'h0, rsp_valid}, 32'h1);
        check("rsp_hold_data", rsp_rdata, 32'h0050_0093);
        repeat (3) @(negedge clk);
        check("rsp_hold_data_late", rsp_rdata, 32'h0050_0093);
        tick();
        hold_rsp = 1'b0;
        drain();

        // Unmapped read and write.
        send_cmd(2'd1, 32'h0003_0000, 32'h0);
        drain();
        send_cmd(2'd0, 32'h0003_0000, 32'h1234_5678);
        check("unm_imem_we", {31'h0, acc_imem_we}, 32'h0);
        check("unm_dmem_wstrb", {28'h0, acc_dmem_wstrb}, 32'h0);

        // Randomized host traffic in HALTED.
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0 || written.size() == 0) begin
                a = rand_addr(r);
                d = $urandom;
                send_cmd(2'd0, a, d);
                check("rnd_imem_we", {31'h0, acc_imem_we}, (region_of(a) == 1) ? 32'h1 : 32'h0);
                check("rnd_dmem_wstrb", {28'h0, acc_dmem_wstrb}, (region_of(a) == 2) ? 32'hF : 32'h0);
                if (region_of(a) == 1) check("rnd_imem_addr", {20'h0, acc_imem_addr}, 32'(widx(a, IMEM_BASE)));
                if (region_of(a) == 2) check("rnd_dmem_addr", {20'h0, acc_dmem_addr}, 32'(widx(a, DMEM_BASE)));
                if (region_of(a) != 0) written.push_back(a);
            end else begin
                a = ($urandom_range(0, 4) == 0) ? rand_addr(0)
                                                : written[$urandom_range(0, written.size() - 1)];
                send_cmd(2'd1, a, 32'h0);
            end
        end
        drain();

        // Program that stores 42 to tohost; bench plays the core.
        prog[0] = 32'h02A0_0093; prog[1] = 32'h0002_0137; prog[2] = 32'h0011_2023;
        for (int k = 0; k < 3; k++) send_cmd(2'd0, 32'(k * 4), prog[k]);
        send_cmd(2'd2, 32'h0, 32'h0);
        check("run_cpu_reset_before", {31'h0, acc_cpu_reset}, 32'h1);
        @(negedge clk);
        check("run_cpu_reset_after", {31'h0, cpu_reset}, 32'h0);
        check("run_running", {31'h0, running}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            cpu_pc = 32'(k * 4);
            @(negedge clk);
            check("fetch_addr", {20'h0, imem_addr}, 32'(k));
            check("fetch_no_we", {31'h0, imem_we}, 32'h0);
            tick();
            check("fetch_instr", cpu_instr, prog[k]);
        end
        cpu_mem_addr = TOHOST; cpu_mem_wdata = 32'd42; cpu_mem_write = 4'hF;
        @(negedge clk);
        check("tohost_not_fwd", {28'h0, dmem_wstrb}, 32'h0);
        tick();
        cpu_mem_write = 4'h0;
        check("tohost_done", {31'h0, done}, 32'h1);
        check("tohost_exit", exit_code, 32'd42);
        check("tohost_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("tohost_halted", {31'h0, running}, 32'h0);

        // Core data stores while running, host back-pressure, HALT.
        send_cmd(2'd2, 32'h0, 32'h0);
        check("run_clears_done", {31'h0, done}, 32'h0);
        d = $urandom;
        cpu_mem_addr = 32'h0001_0008; cpu_mem_wdata = d; cpu_mem_write = 4'hF;
        @(negedge clk);
        check("core_sw_wstrb", {28'h0, dmem_wstrb}, 32'hF);
        check("core_sw_addr", {20'h0, dmem_addr}, 32'h2);
        check("core_sw_wdata", dmem_wdata, d);
        ref_dmem[2] = d;
        tick();
        e = $urandom;
        cpu_mem_addr = 32'h0001_000A; cpu_mem_wdata = e; cpu_mem_write = 4'b1100;
        @(negedge clk);
        check("core_sh_wstrb", {28'h0, dmem_wstrb}, 32'hC);
        for (int b = 2; b < 4; b++) ref_dmem[2][8*b +: 8] = e[8*b +: 8];
        tick();
        cpu_mem_addr = 32'h0000_0100; cpu_mem_write = 4'hF;
        @(negedge clk);
        check("core_imem_store_blocked", {28'h0, dmem_wstrb}, 32'h0);
        tick();
        cpu_mem_write = 4'h0;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'h4; cmd_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("run_backpressure", {31'h0, cmd_ready}, 32'h0);
            check("run_host_no_we", {31'h0, imem_we}, 32'h0);
            tick();
        end
        cmd_op = 2'd3;
        @(negedge clk);
        check("run_halt_ready", {31'h0, cmd_ready}, 32'h1);
        tick();
        cmd_valid = 1'b0;
        check("halt_stops", {31'h0, running}, 32'h0);
        check("halt_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("halt_done_kept", {31'h0, done}, 32'h0);
        check("halt_exit_kept", exit_code, 32'd42);
        send_cmd(2'd1, 32'h0001_0008, 32'h0);
        drain();

        // Tohost store and HALT in the same cycle.
        send_cmd(2'd2, 32'h0, 32'h0);
        cpu_mem_addr = TOHOST; cpu_mem_wdata = 32'd7; cpu_mem_write = 4'h1;
        cmd_valid = 1'b1; cmd_op = 2'd3;
        @(negedge clk);
        check("both_halt_ready", {31'h0, cmd_ready}, 32'h1);
        tick();
        cmd_valid = 1'b0; cpu_mem_write = 4'h0;
        check("both_done", {31'h0, done}, 32'h1);
        check("both_exit", exit_code, 32'd7);
        check("both_halted", {31'h0, running}, 32'h0);

        // HALT while halted is a no-op.
        send_cmd(2'd3, 32'h0, 32'h0);
        check("halt_idle_running", {31'h0, running}, 32'h0);
        check("halt_idle_done", {31'h0, done}, 32'h1);

        // Reset while a response is pending.
        hold_rsp = 1'b1;
        send_cmd(2'd1, 32'h0000_0004, 32'h0);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rsp_before_reset", {31'h0, rsp_valid}, 32'h1);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("rst_rsp_dropped", {31'h0, rsp_valid}, 32'h0);
        check("rst_halted", {31'h0, running}, 32'h0);
        check("rst_cpu_held", {31'h0, cpu_reset}, 32'h1);
        check("rst_done_clr", {31'h0, done}, 32'h0);
        check("rst_exit_clr", exit_code, 32'h0);
        hold_rsp = 1'b0;
        send_cmd(2'd2, 32'h0, 32'h0);
        check("rerun_running", {31'h0, running}, 32'h1);
        check("rerun_done", {31'h0, done}, 32'h0);
        send_cmd(2'd3, 32'h0, 32'h0);
        send_cmd(2'd1, 32'h0000_0004, 32'h0);
        send_cmd(2'd1, 32'h0001_0008, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
